// File: rtl/matrix_feeder.sv
// Matrix operand feeder: loads COLS weight beats, then streams len sign/magnitude converted vectors
// and drains the PE array. Optional per-row output skew is enabled with FEEDER_SKEW_EN.
module matrix_feeder #(
   parameter int ROWS = 4,
   parameter int COLS = 4
) (
   input  logic                 clk,
   input  logic                 res,
   input  logic                 start,
   input  logic                 cfg_width,
   input  logic [15:0]          cfg_len,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [16*ROWS-1:0]   in_data,
   output logic [16*ROWS-1:0]   weight_out,
   output logic                 weight_enable,
   output logic [16*ROWS-1:0]   matrix_out,
   output logic [2*ROWS-1:0]    matrix_sign,
   output logic                 mode_out,
   output logic                 pe_enable,
   output logic                 busy,
   output logic                 done
);

   // state  | meaning
   // IDLE   | waiting for start, all outputs quiet
   // LOAD_W | accepting COLS weight beats onto the weight bus
   // STREAM | accepting len operand beats, bubbles when in_valid is low
   // DRAIN  | ROWS+COLS+1 zero beats to flush the array, then done

   typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

   localparam logic [15:0] LOAD_CNT  = 16'(COLS);
   localparam logic [15:0] DRAIN_CNT = 16'(ROWS + COLS + 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] len_q;
   logic        width_q;
   logic        pe_en_q;
   logic        done_q;
   logic [17:0] stage_q [ROWS];

   // {sign[1:0], magnitude[15:0]} for one 16-bit lane
   function automatic logic [17:0] conv_lane(input logic [15:0] x, input logic w8);
      logic [7:0] hi;
      logic [7:0] lo;
      if (w8) begin
         hi = x[15] ? 8'(~x[15:8] + 8'd1) : x[15:8];
         lo = x[7]  ? 8'(~x[7:0]  + 8'd1) : x[7:0];
         return {x[15], x[7], hi, lo};
      end
      return {x[15], x[15], (x[15] ? 16'(~x + 16'd1) : x)};
   endfunction

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         width_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == IDLE && start) begin
            len_q   <= cfg_len;
            width_q <= cfg_width;
         end
      end
   end

   // cnt_q counts remaining beats down; a phase ends on the beat seen with cnt_q == 1
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD_W;
               cnt_d   = LOAD_CNT;
            end
         end
         LOAD_W: begin
            if (in_valid) begin
               if (cnt_q == 16'd1) begin
                  if (len_q != 16'd0) begin
                     state_d = STREAM;
                     cnt_d   = len_q;
                  end else begin
                     state_d = DRAIN;
                     cnt_d   = DRAIN_CNT;
                  end
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
            end
         end
         STREAM: begin
            if (in_valid) begin
               if (cnt_q == 16'd1) begin
                  state_d = DRAIN;
                  cnt_d   = DRAIN_CNT;
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
            end
         end
         DRAIN: begin
            if (cnt_q == 16'd1) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign busy          = (state_q != IDLE);
   assign in_ready      = (state_q == LOAD_W) || (state_q == STREAM);
   assign weight_enable = (state_q == LOAD_W) && in_valid;
   assign weight_out    = weight_enable ? in_data : '0;
   assign mode_out      = busy ? width_q : 1'b0;
   assign pe_enable     = pe_en_q;
   assign done          = done_q;

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         pe_en_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         pe_en_q <= (state_q == STREAM) || (state_q == DRAIN);
         done_q  <= (state_q == DRAIN) && (cnt_q == 16'd1);
      end
   end

   // bubbles and non-stream cycles feed zero magnitude and zero sign
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         for (int r = 0; r < ROWS; r++) stage_q[r] <= '0;
      end else begin
         for (int r = 0; r < ROWS; r++) begin
            if (state_q == STREAM && in_valid)
               stage_q[r] <= conv_lane(in_data[16*r +: 16], width_q);
            else
               stage_q[r] <= '0;
         end
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [17:0] row_q;
`ifdef FEEDER_SKEW_EN
      if (r == 0) begin : g_direct
         assign row_q = stage_q[r];
      end else begin : g_skew
         logic [17:0] pipe_q [r];
         always_ff @(posedge clk or posedge res) begin
            if (res) begin
               for (int i = 0; i < r; i++) pipe_q[i] <= '0;
            end else begin
               pipe_q[0] <= stage_q[r];
               for (int i = 1; i < r; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end
         assign row_q = pipe_q[r-1];
      end
`else
      assign row_q = stage_q[r];
`endif
      assign matrix_out[16*r +: 16] = row_q[15:0];
      assign matrix_sign[2*r +: 2]  = row_q[17:16];
   end

endmodule

// File: tb/tb_matrix_feeder.sv
// Directed bench for matrix_feeder (ROWS=4, COLS=4): conversion table plus weight-load,
// bubble/drain, mid-job reset and zero-length sequences. Skew expectations follow FEEDER_SKEW_EN.
module tb_matrix_feeder;

   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int NDRN  = ROWS + COLS + 1;
`ifdef FEEDER_SKEW_EN
   localparam int SKEW = 1;
`else
   localparam int SKEW = 0;
`endif

   logic          clk = 1'b0;
   logic          res;
   logic          start;
   logic          cfg_width;
   logic [15:0]   cfg_len;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   in_data;
   logic [63:0]   weight_out;
   logic          weight_enable;
   logic [63:0]   matrix_out;
   logic [7:0]    matrix_sign;
   logic          mode_out;
   logic          pe_enable;
   logic          busy;
   logic          done;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        w;
      logic [63:0] data;
      logic [63:0] mag;
      logic [7:0]  sgn;
   } vec_t;

   vec_t tbl [4];

   matrix_feeder #(.ROWS(ROWS), .COLS(COLS)) dut (
      .clk           (clk),
      .res           (res),
      .start         (start),
      .cfg_width     (cfg_width),
      .cfg_len       (cfg_len),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .weight_out    (weight_out),
      .weight_enable (weight_enable),
      .matrix_out    (matrix_out),
      .matrix_sign   (matrix_sign),
      .mode_out      (mode_out),
      .pe_enable     (pe_enable),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic int row_delay(input int r);
      return (SKEW != 0) ? r : 0;
   endfunction

   task automatic wait_done(input string name, input int max_cyc, output int ncyc);
      ncyc = 0;
      while (done !== 1'b1 && ncyc < max_cyc) begin
         step();
         ncyc++;
      end
      chk({name, " done_seen"}, done, 1'b1);
   endtask

   task automatic check_quiet(input string name);
      chk({name, " matrix_out"},  matrix_out, 64'h0);
      chk({name, " matrix_sign"}, matrix_sign, 8'h0);
      chk({name, " flags"}, {busy, done, pe_enable, in_ready, mode_out, weight_enable}, 6'b0);
      chk({name, " weight_out"},  weight_out, 64'h0);
   endtask

   task automatic load_weights();
      for (int i = 0; i < COLS; i++) begin
         in_valid = 1'b1;
         in_data  = {4{16'h0100 + 16'(i)}};
         step();
      end
   endtask

   // one job of len=1 carrying a single table vector; rows checked at their expected delay
   task automatic run_single(input vec_t v, input string tag);
      int n;
      cfg_width = v.w;
      cfg_len   = 16'd1;
      start     = 1'b1;
      step();
      start = 1'b0;
      load_weights();
      in_valid = 1'b1;
      in_data  = v.data;
      step();
      in_valid = 1'b0;
      in_data  = 64'h0;
      for (int k = 0; k < ROWS; k++) begin
         #1;
         for (int r = 0; r < ROWS; r++) begin
            if (row_delay(r) == k) begin
               chk({tag, " mag"},  matrix_out[16*r +: 16], v.mag[16*r +: 16]);
               chk({tag, " sign"}, matrix_sign[2*r +: 2],  v.sgn[2*r +: 2]);
            end
         end
         if (k == 0) chk({tag, " mode_out"}, mode_out, v.w);
         if (k < ROWS - 1) step();
      end
      wait_done(tag, 40, n);
      chk({tag, " idle_at_done"}, busy, 1'b0);
   endtask

   initial begin
      int n;
      int npulse;
      int wi;
      bit         wpat [7]  = '{1, 0, 1, 0, 1, 0, 1};
      logic [63:0] wdat [4] = '{64'h1111_2222_3333_4444, 64'h8000_7FFF_0001_FFFF,
                                64'hA5A5_5A5A_0F0F_F0F0, 64'h0123_4567_89AB_CDEF};
      bit          spat [5] = '{1, 0, 0, 1, 1};
      logic [63:0] sdat [5] = '{64'h1111_2222_3333_FF01, 64'hDEAD_BEEF_DEAD_BEEF,
                                64'hDEAD_BEEF_DEAD_BEEF, 64'h4444_5555_6666_7FFE,
                                64'h7777_8888_9999_8080};
      logic [15:0] smag [5] = '{16'h0101, 16'h0000, 16'h0000, 16'h7F02, 16'h8080};
      logic [1:0]  ssgn [5] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b11};

      tbl[0] = '{1'b0, 64'h0000_7FFF_8000_FFFF, 64'h0000_7FFF_8000_0001, 8'b00_00_11_11};
      tbl[1] = '{1'b1, 64'h8181_0180_FF7F_8005, 64'h7F7F_0180_017F_8005, 8'b11_01_10_10};
      tbl[2] = '{1'b0, 64'h8001_C000_FFFE_1234, 64'h7FFF_4000_0002_1234, 8'b11_11_11_00};
      tbl[3] = '{1'b1, 64'h0000_FE02_7F80_00FF, 64'h0000_0202_7F80_0001, 8'b00_10_01_01};

      res       = 1'b1;
      start     = 1'b0;
      cfg_width = 1'b0;
      cfg_len   = 16'd0;
      in_valid  = 1'b0;
      in_data   = 64'h0;
      step();
      step();
      check_quiet("reset");
      res = 1'b0;
      step();

      for (int i = 0; i < 4; i++) run_single(tbl[i], $sformatf("vec%0d", i));

      // weight load with in_valid toggling, start re-asserted mid-job must be ignored
      cfg_width = 1'b1;
      cfg_len   = 16'd3;
      start     = 1'b1;
      step();
      start     = 1'b0;
      cfg_width = 1'b0;
      cfg_len   = 16'd7;
      npulse    = 0;
      wi        = 0;
      for (int c = 0; c < 7; c++) begin
         in_valid = wpat[c];
         in_data  = wpat[c] ? wdat[wi] : 64'hFACE_FACE_FACE_FACE;
         start    = (c == 1);
         #1;
         chk("loadw in_ready", in_ready, 1'b1);
         chk("loadw weight_enable", weight_enable, wpat[c]);
         if (wpat[c]) chk("loadw weight_out", weight_out, wdat[wi]);
         if (weight_enable) npulse++;
         step();
         if (wpat[c]) wi++;
      end
      start = 1'b0;
      chk("loadw pulse_count", 64'(npulse), 64'd4);

      // stream len=3 with two bubbles, then timed drain
      for (int c = 0; c < 5; c++) begin
         in_valid = spat[c];
         in_data  = sdat[c];
         #1;
         chk("stream in_ready", in_ready, 1'b1);
         chk("stream no_weight_en", weight_enable, 1'b0);
         chk("stream mode_out", mode_out, 1'b1);
         if (c == 0) chk("stream pe_enable_first", pe_enable, 1'b0);
         else begin
            chk("stream pe_enable", pe_enable, 1'b1);
            chk("stream row0 mag",  matrix_out[15:0], smag[c-1]);
            chk("stream row0 sign", matrix_sign[1:0], ssgn[c-1]);
         end
         step();
      end
      in_valid = 1'b0;
      in_data  = 64'h0;
      #1;
      chk("drain row0 mag",  matrix_out[15:0], smag[4]);
      chk("drain row0 sign", matrix_sign[1:0], ssgn[4]);
      chk("drain in_ready", in_ready, 1'b0);
      chk("drain busy", busy, 1'b1);
      wait_done("drain", 40, n);
      chk("drain done_latency", 64'(n), 64'(NDRN));
      chk("drain pe_enable_at_done", pe_enable, 1'b1);
      chk("drain busy_at_done", busy, 1'b0);
      step();
      chk("drain done_pulse", done, 1'b0);
      chk("drain pe_enable_after", pe_enable, 1'b0);

      // reset asserted mid-stream
      cfg_width = 1'b0;
      cfg_len   = 16'd5;
      start     = 1'b1;
      step();
      start = 1'b0;
      load_weights();
      in_valid = 1'b1;
      in_data  = 64'h0001_0001_0001_FFFF;
      step();
      step();
      chk("midreset pre_busy", busy, 1'b1);
      chk("midreset pre_row0", matrix_out[15:0], 16'h0001);
      res = 1'b1;
      #1;
      in_valid = 1'b0;
      #1;
      check_quiet("midreset async");
      in_valid = 1'b1;
      step();
      #1;
      check_quiet("midreset held");
      res      = 1'b0;
      in_valid = 1'b0;
      step();
      step();
      step();
      chk("midreset stays_idle", busy, 1'b0);
      run_single(tbl[2], "post_reset");

      // zero-length job: weights then straight to drain, one done pulse
      cfg_width = 1'b1;
      cfg_len   = 16'd0;
      start     = 1'b1;
      step();
      start = 1'b0;
      load_weights();
      in_valid = 1'b0;
      #1;
      chk("len0 in_ready", in_ready, 1'b0);
      chk("len0 busy", busy, 1'b1);
      chk("len0 matrix_out", matrix_out, 64'h0);
      wait_done("len0", 40, n);
      chk("len0 done_latency", 64'(n), 64'(NDRN));
      npulse = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (done) npulse++;
      end
      chk("len0 extra_done", 64'(npulse), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
